// File: rtl/param_updown_counter_if.sv
// rtl/param_updown_counter_if.sv - control/status bundle for the parametrised up/down counter

interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             En;
    logic             UpOrDown;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Step;
    logic             ClrErr;
    logic [WIDTH-1:0] Count;
    logic             Wrap;
    logic             Tc;
    logic             CarryOut;
    logic             Err;

    // Side that drives the controls and observes the count.
    modport master (
        output En,
        output UpOrDown,
        output Load,
        output LoadVal,
        output Step,
        output ClrErr,
        input  Count,
        input  Wrap,
        input  Tc,
        input  CarryOut,
        input  Err
    );

    // The counter itself.
    modport slave (
        input  En,
        input  UpOrDown,
        input  Load,
        input  LoadVal,
        input  Step,
        input  ClrErr,
        output Count,
        output Wrap,
        output Tc,
        output CarryOut,
        output Err
    );
endinterface

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - modulo-N up/down counter with step, load, wrap/saturate and sticky error

module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    param_updown_counter_if.slave bus
);

    // A modulus outside 2..2^WIDTH cannot be represented; refuse to elaborate.
    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // Arithmetic is done one bit wider than the count so sums never overflow.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             err_q;

    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             err_set;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] up_wrapped;
    logic [WIDTH-1:0] down_wrapped;

    // Next-state selection: Load beats En beats hold. A zero step falls
    // through the up/down paths as a hold with no crossing.
    always_comb begin
        count_ext    = {1'b0, count_q};
        step_ext     = {1'b0, bus.Step};
        load_ext     = {1'b0, bus.LoadVal};
        sum_up       = count_ext + step_ext;
        up_wrapped   = WIDTH'(sum_up - MOD_EXT);
        down_wrapped = WIDTH'(count_ext + MOD_EXT - step_ext);

        count_d = count_q;
        wrap_d  = 1'b0;
        err_set = 1'b0;

        if (bus.Load) begin
            if (load_ext < MOD_EXT) begin
                count_d = bus.LoadVal;
            end else begin
                count_d = MAX_CNT;
                err_set = 1'b1;
            end
        end else if (bus.En) begin
            if (step_ext >= MOD_EXT) begin
                // A step this large has no meaning in the count range; hold and flag it.
                err_set = 1'b1;
            end else if (bus.UpOrDown) begin
                if (sum_up <= MAX_EXT) begin
                    count_d = sum_up[WIDTH-1:0];
                end else begin
                    wrap_d  = 1'b1;
                    count_d = (SATURATE != 0) ? MAX_CNT : up_wrapped;
                end
            end else begin
                if (count_ext >= step_ext) begin
                    count_d = WIDTH'(count_ext - step_ext);
                end else begin
                    wrap_d  = 1'b1;
                    count_d = (SATURATE != 0) ? '0 : down_wrapped;
                end
            end
        end
    end

    // State registers; Err is sticky and a new error outranks a same-cycle clear.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_set | (err_q & ~bus.ClrErr);
        end
    end

    // Terminal count looks at the boundary in the current direction of travel.
    always_comb begin
        bus.Tc = bus.UpOrDown ? (count_q == MAX_CNT) : (count_q == '0);
    end

    // Cascade enable is only meaningful for unit steps, where Tc marks the wrap edge.
    always_comb begin
        bus.CarryOut = bus.Tc & bus.En & (bus.Step == WIDTH'(1));
    end

    assign bus.Count = count_q;
    assign bus.Wrap  = wrap_q;
    assign bus.Err   = err_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - directed vector bench for param_updown_counter

module tb_param_updown_counter;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    param_updown_counter_if #(.WIDTH(4)) if_dflt ();
    param_updown_counter_if #(.WIDTH(4)) if_sat ();
    param_updown_counter_if #(.WIDTH(4)) if_units ();
    param_updown_counter_if #(.WIDTH(4)) if_tens ();
    param_updown_counter_if #(.WIDTH(8)) if_wide ();

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dflt (
        .Clk(clk), .reset_n(rst_n), .bus(if_dflt));
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .Clk(clk), .reset_n(rst_n), .bus(if_sat));
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_units (
        .Clk(clk), .reset_n(rst_n), .bus(if_units));
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_tens (
        .Clk(clk), .reset_n(rst_n), .bus(if_tens));
    param_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_wide (
        .Clk(clk), .reset_n(rst_n), .bus(if_wide));

    assign if_tens.En = if_units.CarryOut;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] load_val;
        logic [3:0] step;
        logic       clr_err;
        logic [3:0] exp_count;
        logic       exp_wrap;
        logic       exp_err;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic l, input logic e, input logic u, input int lv, input int st,
                       input logic ce, input int ec, input logic ew, input logic ee, input logic et);
        vec_t v;
        v.load = l; v.en = e; v.up = u; v.load_val = 4'(lv); v.step = 4'(st); v.clr_err = ce;
        v.exp_count = 4'(ec); v.exp_wrap = ew; v.exp_err = ee; v.exp_tc = et;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        //          ld en up lv st ce  cnt w  e  tc
        // up count through the wrap
        add(0, 1, 1, 0, 1, 0,  1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  2, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  3, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  4, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  5, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  6, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  7, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  8, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0,  9, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0,  0, 1, 0, 0);
        add(0, 1, 1, 0, 1, 0,  1, 0, 0, 0);
        // load then down by 3 with wraps
        add(1, 1, 0, 2, 3, 0,  2, 0, 0, 0);
        add(0, 1, 0, 0, 3, 0,  9, 1, 0, 0);
        add(0, 1, 0, 0, 3, 0,  6, 0, 0, 0);
        add(0, 1, 0, 0, 3, 0,  3, 0, 0, 0);
        add(0, 1, 0, 0, 3, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 3, 0,  7, 1, 0, 0);
        // load priority and error handling
        add(1, 1, 1, 5, 1, 0,  5, 0, 0, 0);
        add(1, 0, 1, 12, 1, 0, 9, 0, 1, 1);
        add(0, 1, 1, 0, 10, 0, 9, 0, 1, 1);
        add(0, 1, 1, 0, 11, 1, 9, 0, 1, 1);
        add(0, 0, 1, 0, 1, 1,  9, 0, 0, 1);
        // hold and zero step
        add(0, 0, 0, 0, 1, 0,  9, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  9, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0,  9, 0, 0, 1);
        // load boundaries and large legal steps
        add(1, 0, 0, 9, 0, 0,  9, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 9, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1,  9, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0,  9, 1, 0, 0);
        add(0, 1, 1, 0, 9, 0,  8, 1, 0, 0);
        add(0, 1, 0, 0, 9, 0,  9, 1, 0, 0);

        rst_n = 1'b0;
        foreach (vecs[i]) begin end
        if_dflt.En = 0; if_dflt.UpOrDown = 0; if_dflt.Load = 0; if_dflt.LoadVal = 0; if_dflt.Step = 0; if_dflt.ClrErr = 0;
        if_sat.En = 0; if_sat.UpOrDown = 0; if_sat.Load = 0; if_sat.LoadVal = 0; if_sat.Step = 0; if_sat.ClrErr = 0;
        if_units.En = 0; if_units.UpOrDown = 0; if_units.Load = 0; if_units.LoadVal = 0; if_units.Step = 0; if_units.ClrErr = 0;
        if_tens.UpOrDown = 0; if_tens.Load = 0; if_tens.LoadVal = 0; if_tens.Step = 0; if_tens.ClrErr = 0;
        if_wide.En = 0; if_wide.UpOrDown = 0; if_wide.Load = 0; if_wide.LoadVal = 0; if_wide.Step = 0; if_wide.ClrErr = 0;

        #12;
        chk("reset count", int'(if_dflt.Count), 0);
        chk("reset wrap", int'(if_dflt.Wrap), 0);
        chk("reset err", int'(if_dflt.Err), 0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if_dflt.Load     = vecs[i].load;
            if_dflt.En       = vecs[i].en;
            if_dflt.UpOrDown = vecs[i].up;
            if_dflt.LoadVal  = vecs[i].load_val;
            if_dflt.Step     = vecs[i].step;
            if_dflt.ClrErr   = vecs[i].clr_err;
            tick();
            chk($sformatf("vec%0d count", i), int'(if_dflt.Count), int'(vecs[i].exp_count));
            chk($sformatf("vec%0d wrap", i), int'(if_dflt.Wrap), int'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d err", i), int'(if_dflt.Err), int'(vecs[i].exp_err));
            chk($sformatf("vec%0d tc", i), int'(if_dflt.Tc), int'(vecs[i].exp_tc));
        end

        // Asynchronous reset between edges clears count and sticky error at once.
        if_dflt.Load = 1; if_dflt.En = 0; if_dflt.LoadVal = 4'd12; if_dflt.ClrErr = 0;
        tick();
        chk("pre-reset err", int'(if_dflt.Err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset count", int'(if_dflt.Count), 0);
        chk("async reset err", int'(if_dflt.Err), 0);
        if_dflt.Load = 0;
        #2;
        rst_n = 1'b1;

        // Two-digit cascade: tens enabled by units CarryOut.
        if_units.En = 1; if_units.UpOrDown = 1; if_units.Step = 4'd1;
        if_tens.UpOrDown = 1; if_tens.Step = 4'd1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk($sformatf("cascade%0d units", i), int'(if_units.Count), i % 10);
            chk($sformatf("cascade%0d tens", i), int'(if_tens.Count), i / 10);
            chk($sformatf("cascade%0d carry", i), int'(if_units.CarryOut), ((i % 10) == 9) ? 1 : 0);
        end
        if_units.En = 0;

        // Saturating instance: clamp at 9 going up, at 0 going down.
        if_sat.Load = 1; if_sat.LoadVal = 4'd8; if_sat.Step = 4'd3; if_sat.UpOrDown = 1; if_sat.En = 1;
        tick();
        chk("sat load count", int'(if_sat.Count), 8);
        if_sat.Load = 0;
        tick();
        chk("sat up1 count", int'(if_sat.Count), 9);
        chk("sat up1 wrap", int'(if_sat.Wrap), 1);
        tick();
        chk("sat up2 count", int'(if_sat.Count), 9);
        chk("sat up2 wrap", int'(if_sat.Wrap), 1);
        if_sat.UpOrDown = 0;
        tick();
        chk("sat dn1 count", int'(if_sat.Count), 6);
        chk("sat dn1 wrap", int'(if_sat.Wrap), 0);
        tick();
        chk("sat dn2 count", int'(if_sat.Count), 3);
        tick();
        chk("sat dn3 count", int'(if_sat.Count), 0);
        chk("sat dn3 wrap", int'(if_sat.Wrap), 0);
        tick();
        chk("sat dn4 count", int'(if_sat.Count), 0);
        chk("sat dn4 wrap", int'(if_sat.Wrap), 1);
        tick();
        chk("sat dn5 count", int'(if_sat.Count), 0);
        chk("sat dn5 wrap", int'(if_sat.Wrap), 1);
        chk("sat tc", int'(if_sat.Tc), 1);
        chk("sat err", int'(if_sat.Err), 0);
        if_sat.En = 0;

        // Wide instance: full 2^WIDTH modulus wraps through the carry bit.
        if_wide.Load = 1; if_wide.LoadVal = 8'd250; if_wide.UpOrDown = 1; if_wide.Step = 8'd10;
        tick();
        chk("wide load count", int'(if_wide.Count), 250);
        if_wide.Load = 0; if_wide.En = 1;
        tick();
        chk("wide wrap count", int'(if_wide.Count), 4);
        chk("wide wrap pulse", int'(if_wide.Wrap), 1);
        chk("wide err", int'(if_wide.Err), 0);
        tick();
        chk("wide next count", int'(if_wide.Count), 14);
        chk("wide next wrap", int'(if_wide.Wrap), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
